lsu_ctrl: RTL

- Load/store unit between the execute stage and data memory.
- Consumes the decoder's mem_rd / mem_wr / mask (funct3) controls, the ALU-computed effective address and the rs2 store data.
- Runs a req/gnt/rvalid handshake to data memory, aligns byte lanes, and sign/zero-extends load data for the write-back mux (sel_wb = 0 path).
- Stalls the pipeline while an access is in flight.

---
 rtl/lsu_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit between execute and data memory. It decodes size and sign,
// drives the req/gnt/rvalid handshake, steers byte lanes, and holds the pipeline while busy.
//
// state | meaning
// IDLE  | ready to accept an access
// REQ   | dmem_req_o held with stable fields until dmem_gnt_i
// WAIT  | load granted, waiting for dmem_rvalid_i
// RESP  | rdata_o valid, rdata_valid_o pulses, new access may be accepted
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  mask_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    be_q, be_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          rvld_q, rvld_d;
  logic          mis_q, mis_d;
  logic          to_q, to_d;

  logic          access, illegal, misaligned, ready, accept;
  logic [1:0]    size_in;
  logic [3:0]    be_in;
  logic [31:0]   wdata_in;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;
  logic [CW-1:0] cnt_inc;
  logic          cnt_hit;

  assign size_in    = mask_i[1:0];
  assign access     = valid_i & (mem_rd_i | mem_wr_i);
  assign illegal    = (mem_rd_i & mem_wr_i) | (mask_i == 3'b011) |
                      (mask_i[2] & mask_i[1]) | (mask_i[2] & mem_wr_i);
  assign misaligned = ((size_in == 2'b01) & addr_i[0]) |
                      ((size_in == 2'b10) & (|addr_i[1:0]));
  assign ready      = (state_q == IDLE) | (state_q == RESP);
  assign accept     = ready & access & ~illegal & ~misaligned;

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = wdata_i;
    case (size_in)
      2'b00: begin
        be_in    = 4'b0001 << addr_i[1:0];
        wdata_in = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << addr_i[1:0];
        wdata_in = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = dmem_rdata_i[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    ld_ext = dmem_rdata_i;
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // Counter runs across REQ and WAIT together; TIMEOUT of zero never hits.
  assign cnt_inc = cnt_q + CW'(1);
  assign cnt_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          state_d = REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = mem_wr_i;
          addr_d  = {addr_i[31:2], 2'b00};
          wdata_d = wdata_in;
          be_d    = be_in;
          off_d   = addr_i[1:0];
          size_d  = size_in;
          uns_d   = mask_i[2];
        end else if (access) begin
          mis_d = 1'b1;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (dmem_gnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? IDLE : WAIT;
        end else if (cnt_hit) begin
          req_d   = 1'b0;
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (dmem_rvalid_i) begin
          rdata_d = ld_ext;
          rvld_d  = 1'b1;
          state_d = RESP;
        end else if (cnt_hit) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  // Acceptance stalls combinationally; gated so every output reads 0 in reset.
  assign stall_o       = ~rst_i & (accept | (state_q == REQ) | (state_q == WAIT));
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvld_q;
  assign misalign_o    = mis_q;
  assign timeout_o     = to_q;
  assign dmem_req_o    = req_q;
  assign dmem_we_o     = we_q;
  assign dmem_addr_o   = addr_q;
  assign dmem_be_o     = be_q;
  assign dmem_wdata_o  = wdata_q;

endmodule
